// File: rtl/bus_pkg.sv
// ============================================================================
// Module   : bus_pkg
// Brief    : Shared types and constants for the write-bus register target.
// Revision : 1.0
// ============================================================================
`default_nettype none

package bus_pkg;

    localparam int BUS_AW = 32;
    localparam int BUS_DW = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        COMMIT = 2'd2
    } bus_tgt_state_t;

    typedef struct packed {
        logic [BUS_AW-1:0] addr;
        logic [BUS_DW-1:0] data;
    } bus_wr_t;

    localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

endpackage

`default_nettype wire

// File: rtl/bus_fifo.sv
// ============================================================================
// Module   : bus_fifo
// Brief    : Synchronous FIFO, no read-through bypass; storage is not reset.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bus_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           din_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= din_i;
    end

endmodule

`default_nettype wire

// File: rtl/bus_reg_target.sv
// ============================================================================
// Module   : bus_reg_target
// Brief    : Write-bus responder: queues transfers, commits to a register bank
//            after a fixed latency, flags and counts invalid addresses.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bus_reg_target
    import bus_pkg::*;
#(
    parameter int BAW   = 32,
    parameter int BDW   = 32,
    parameter int NREG  = 8,
    parameter int DEPTH = 4,
    parameter int WLAT  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wvalid,
    output logic                  wready,
    input  logic [BAW-1:0]        waddr,
    input  logic [BDW-1:0]        wdata,
    output logic [NREG*BDW-1:0]   reg_q,
    output logic [NREG-1:0]       upd,
    output logic                  err,
    output logic [7:0]            err_cnt,
    output logic                  busy
);

    localparam int CW   = $clog2(DEPTH) + 1;
    localparam int LATW = (WLAT > 1) ? $clog2(WLAT) : 1;
    localparam int IDXW = BAW - 2;
    localparam logic [LATW-1:0] LAT_INIT = LATW'(WLAT - 1);

    bus_tgt_state_t     state_q, state_d;
    logic [LATW-1:0]    lat_q, lat_d;
    logic [BAW-1:0]     hold_addr_q, hold_addr_d;
    logic [BDW-1:0]     hold_data_q, hold_data_d;
    logic [BDW-1:0]     bank_q [NREG];
    logic [BDW-1:0]     bank_d [NREG];
    logic [NREG-1:0]    upd_q, upd_d;
    logic               err_q, err_d;
    logic [7:0]         err_cnt_q, err_cnt_d;
    logic               wready_q, wready_d;

    logic               push;
    logic               pop;
    logic [BAW-1:0]     head_addr;
    logic [BDW-1:0]     head_data;
    logic [CW-1:0]      count;
    logic [CW-1:0]      count_next;
    logic               fifo_full;
    logic               fifo_empty;
    logic [IDXW-1:0]    idx;
    logic               addr_ok;

    bus_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (BAW + BDW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   ({waddr, wdata}),
        .dout_o  ({head_addr, head_data}),
        .count_o (count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign push       = wvalid && wready_q && !fifo_full;
    assign count_next = count + CW'(push) - CW'(pop);
    // Registered ready: low for the cycle after the queue reaches DEPTH, so a
    // same-edge pop never makes room for a push.
    assign wready_d   = (count_next != CW'(DEPTH));

    assign idx     = hold_addr_q[BAW-1:2];
    assign addr_ok = (hold_addr_q[1:0] == 2'b00) && (idx < IDXW'(NREG));

    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        hold_addr_d = hold_addr_q;
        hold_data_d = hold_data_q;
        bank_d      = bank_q;
        upd_d       = upd_q;
        err_d       = err_q;
        err_cnt_d   = err_cnt_q;
        pop         = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    hold_addr_d = head_addr;
                    hold_data_d = head_data;
                    lat_d       = LAT_INIT;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (lat_q == '0) begin
                    upd_d = '0;
                    if (addr_ok) begin
                        for (int i = 0; i < NREG; i++) begin
                            if (idx == IDXW'(i)) begin
                                bank_d[i] = hold_data_q;
                                upd_d[i]  = 1'b1;
                            end
                        end
                    end else begin
                        err_d = 1'b1;
                        if (err_cnt_q != ERR_CNT_MAX) err_cnt_d = err_cnt_q + 8'd1;
                    end
                    state_d = COMMIT;
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            COMMIT: begin
                upd_d = '0;
                err_d = 1'b0;
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    hold_addr_d = head_addr;
                    hold_data_d = head_data;
                    lat_d       = LAT_INIT;
                    state_d     = WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            lat_q       <= '0;
            hold_addr_q <= '0;
            hold_data_q <= '0;
            upd_q       <= '0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
            wready_q    <= 1'b0;
            for (int i = 0; i < NREG; i++) bank_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            hold_addr_q <= hold_addr_d;
            hold_data_q <= hold_data_d;
            upd_q       <= upd_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
            wready_q    <= wready_d;
            for (int i = 0; i < NREG; i++) bank_q[i] <= bank_d[i];
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : g_reg_out
        assign reg_q[g*BDW +: BDW] = bank_q[g];
    end

    assign wready  = wready_q;
    assign upd     = upd_q;
    assign err     = err_q;
    assign err_cnt = err_cnt_q;
    assign busy    = (count != '0) || (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_bus_reg_target.sv
// ============================================================================
// Module   : tb_bus_reg_target
// Brief    : Directed self-checking bench for bus_reg_target (default params).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bus_reg_target;
    import bus_pkg::*;

    logic         clk;
    logic         rst;
    logic         wvalid;
    logic         wready;
    logic [31:0]  waddr;
    logic [31:0]  wdata;
    logic [255:0] reg_q;
    logic [7:0]   upd;
    logic         err;
    logic [7:0]   err_cnt;
    logic         busy;

    int total = 0;
    int bad   = 0;
    int n_err;
    int n_upd1;
    int n_upd_any;
    logic [255:0] exp_bank;

    bus_reg_target dut (
        .clk     (clk),
        .rst     (rst),
        .wvalid  (wvalid),
        .wready  (wready),
        .waddr   (waddr),
        .wdata   (wdata),
        .reg_q   (reg_q),
        .upd     (upd),
        .err     (err),
        .err_cnt (err_cnt),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a transfer at a falling edge and hold it until accepted.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        int guard;
        @(negedge clk);
        wvalid = 1'b1;
        waddr  = a;
        wdata  = d;
        guard  = 0;
        while (!wready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk("wr_accept_timeout", 0, 1);
        @(posedge clk);
        #1 wvalid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        n_err = 0;
        n_upd1 = 0;
        n_upd_any = 0;
        guard = 0;
        do begin
            @(negedge clk);
            if (err) n_err++;
            if (upd[1]) n_upd1++;
            if (upd != 8'h00) n_upd_any++;
            guard++;
        end while (busy && guard < 2000);
        if (guard >= 2000) chk("wait_idle_timeout", 0, 1);
    endtask

    initial begin
        rst = 1'b1; wvalid = 1'b0; waddr = '0; wdata = '0;
        exp_bank = '0;
        #2 rst = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_wready", wready, 0);
        chk("rst_reg_q", reg_q, 0);
        chk("rst_upd", upd, 0);
        chk("rst_err", err, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b1;
        @(posedge clk);
        #1 chk("wready_after_release", wready, 1);

        // Single write, 3-edge latency, one-cycle upd
        wr(32'h08, 32'hDEADBEEF);          // accepted at T
        @(posedge clk); @(posedge clk);    // T+2
        #1 chk("single_not_yet", reg_q, 0);
        @(posedge clk);                    // T+3
        exp_bank[2*32 +: 32] = 32'hDEADBEEF;
        #1 chk("single_reg2", reg_q, exp_bank);
        chk("single_upd", upd, 8'b0000_0100);
        @(posedge clk);
        #1 chk("single_upd_clear", upd, 0);
        wait_idle();

        // Burst of 6: queue fills and wready drops
        for (int i = 0; i < 6; i++) wr(32'(i * 4), 32'h100 + 32'(i));
        chk("burst_wready_low", wready, 0);
        chk("burst_count_full", dut.u_fifo.count_o, 4);
        wait_idle();
        for (int i = 0; i < 6; i++) exp_bank[i*32 +: 32] = 32'h100 + 32'(i);
        chk("burst_regs", reg_q, exp_bank);
        chk("burst_busy_low", busy, 0);
        chk("burst_wready_back", wready, 1);

        // Invalid addresses
        wr(32'h20, 32'hAAAA_AAAA);
        wr(32'h05, 32'hBBBB_BBBB);
        wait_idle();
        chk("inv_err_pulses", n_err, 2);
        chk("inv_no_upd", n_upd_any, 0);
        chk("inv_err_cnt", err_cnt, 2);
        chk("inv_bank_same", reg_q, exp_bank);

        // Saturation: 253 more reaches 255, then 47 more stays there
        for (int i = 0; i < 253; i++) wr(32'h100, 32'(i));
        wait_idle();
        chk("sat_reach", err_cnt, 8'hFF);
        for (int i = 0; i < 47; i++) wr(32'h101, 32'(i));
        wait_idle();
        chk("sat_hold", err_cnt, 8'hFF);
        chk("sat_bank_same", reg_q, exp_bank);

        // Same register twice: last wins, two strobes
        wr(32'h04, 32'h1);
        wr(32'h04, 32'h2);
        wait_idle();
        exp_bank[1*32 +: 32] = 32'h2;
        chk("dup_reg1", reg_q, exp_bank);
        chk("dup_upd1_pulses", n_upd1, 2);

        // Reset while in WAIT with 3 queued
        for (int i = 0; i < 5; i++) wr(32'h18, 32'h61 + 32'(i));
        chk("pre_rst_state", dut.state_q, WAIT);
        chk("pre_rst_count", dut.u_fifo.count_o, 3);
        rst = 1'b0;
        #1;
        exp_bank = '0;
        chk("arst_wready", wready, 0);
        chk("arst_reg_q", reg_q, 0);
        chk("arst_err_cnt", err_cnt, 0);
        chk("arst_busy", busy, 0);
        chk("arst_upd_err", {upd, err}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        n_upd_any = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (upd != 8'h00) n_upd_any++;
        end
        chk("post_rst_no_commit", n_upd_any, 0);
        chk("post_rst_reg_q", reg_q, 0);

        // Push+pop at count 3 and ordering across pointer wrap
        for (int i = 0; i < 10; i++) begin
            wr(32'((i % 8) * 4), 32'h500 + 32'(i));
            if (i == 3) chk("cnt3_push_only", dut.u_fifo.count_o, 3);
            if (i == 4) chk("cnt3_push_pop", dut.u_fifo.count_o, 3);
        end
        wait_idle();
        for (int i = 2; i < 8; i++) exp_bank[i*32 +: 32] = 32'h500 + 32'(i);
        exp_bank[0*32 +: 32] = 32'h508;
        exp_bank[1*32 +: 32] = 32'h509;
        chk("wrap_order", reg_q, exp_bank);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
